// File: rtl/dechuff_rle_expand.sv
// Run-length expander: turns Huffman run/value tokens into one zigzag-ordered
// coefficient per beat, NCOEF per block, with DC, ZRL, EOB fill and end-of-stream beats.
module dechuff_rle_expand #(
   parameter int CW    = 12,
   parameter int NCOEF = 64
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic [15:0]              parsedToken_d,
   input  logic                     parsedToken_e,
   input  logic                     parsedToken_v,
   output logic                     parsedToken_b,
   output logic [15:0]              coef_d,
   output logic [$clog2(NCOEF)-1:0] coef_idx,
   output logic                     coef_e,
   output logic                     coef_v,
   input  logic                     coef_b,
   output logic                     err
);
   localparam int IW = $clog2(NCOEF);
   localparam logic [IW-1:0] LAST_IDX = IW'(NCOEF - 1);

   typedef enum logic [2:0] {ST_IDLE, ST_ZERO, ST_COEF, ST_FILL, ST_EOS} state_t;

   state_t        state_q, state_d, eff_state_s;
   logic [IW-1:0] idx_q, idx_d, idx_inc_s;
   logic [4:0]    zcnt_q, zcnt_d, eff_zcnt_s;
   logic [CW-1:0] val_q, val_d, eff_val_s;
   logic          zrl_q, zrl_d, eff_zrl_s;
   logic          pend_e_q, pend_e_d, eff_pend_e_s;
   logic          err_q, err_d;
   logic          coef_v_q, coef_v_d;
   logic          coef_e_q, coef_e_d;
   logic [15:0]   coef_d_q, coef_d_d;
   logic [IW-1:0] coef_idx_q, coef_idx_d;
   logic          adv_s, accept_s, last_s;
   logic [3:0]    tok_run_s;
   logic [CW-1:0] tok_val_s;

   function automatic logic [15:0] sext(input logic [CW-1:0] v);
      return {{(16-CW){v[CW-1]}}, v};
   endfunction

   // Handshake and token decode; an accepted token is executed in the same cycle,
   // so its first beat is loaded into the output register on the accepting edge.
   always_comb begin
      adv_s         = !coef_v_q || !coef_b;
      parsedToken_b = !((state_q == ST_IDLE) && adv_s);
      accept_s      = (state_q == ST_IDLE) && adv_s && parsedToken_v;
      tok_run_s     = parsedToken_d[15:12];
      tok_val_s     = parsedToken_d[CW-1:0];
      last_s        = (idx_q == LAST_IDX);
      idx_inc_s     = last_s ? {IW{1'b0}} : idx_q + IW'(1);
      eff_state_s   = state_q;
      eff_zcnt_s    = zcnt_q;
      eff_val_s     = val_q;
      eff_zrl_s     = zrl_q;
      eff_pend_e_s  = pend_e_q;
      if (accept_s) begin
         eff_val_s = tok_val_s;
         eff_zrl_s = 1'b0;
         if (parsedToken_e) begin
            eff_val_s = {CW{1'b0}};
            if (idx_q == {IW{1'b0}}) begin
               eff_state_s = ST_EOS;
            end else begin
               eff_state_s  = ST_FILL;
               eff_pend_e_s = 1'b1;
            end
         end else if (idx_q == {IW{1'b0}}) begin
            eff_state_s = ST_COEF;
         end else if (tok_run_s == 4'd0 && tok_val_s == {CW{1'b0}}) begin
            eff_state_s = ST_FILL;
         end else if (tok_run_s == 4'd15 && tok_val_s == {CW{1'b0}}) begin
            eff_state_s = ST_ZERO;
            eff_zcnt_s  = 5'd16;
            eff_zrl_s   = 1'b1;
         end else if (tok_run_s != 4'd0) begin
            eff_state_s = ST_ZERO;
            eff_zcnt_s  = {1'b0, tok_run_s};
         end else begin
            eff_state_s = ST_COEF;
         end
      end else begin
         eff_state_s = state_q;
      end
   end

   // One expansion step per output advance.
   always_comb begin
      state_d    = eff_state_s;
      idx_d      = idx_q;
      zcnt_d     = eff_zcnt_s;
      val_d      = eff_val_s;
      zrl_d      = eff_zrl_s;
      pend_e_d   = eff_pend_e_s;
      err_d      = err_q;
      coef_v_d   = coef_v_q;
      coef_e_d   = coef_e_q;
      coef_d_d   = coef_d_q;
      coef_idx_d = coef_idx_q;
      if (adv_s) begin
         coef_v_d   = 1'b1;
         coef_e_d   = 1'b0;
         coef_d_d   = 16'd0;
         coef_idx_d = idx_q;
         case (eff_state_s)
            ST_ZERO: begin
               idx_d  = idx_inc_s;
               zcnt_d = eff_zcnt_s - 5'd1;
               if (last_s) begin
                  // Past the block end only a ZRL finishing exactly here is legal.
                  state_d = ST_IDLE;
                  zrl_d   = 1'b0;
                  if (!(eff_zcnt_s == 5'd1 && eff_zrl_s)) begin
                     err_d = 1'b1;
                  end else begin
                     err_d = err_q;
                  end
               end else if (eff_zcnt_s == 5'd1) begin
                  state_d = eff_zrl_s ? ST_IDLE : ST_COEF;
                  zrl_d   = 1'b0;
               end else begin
                  state_d = ST_ZERO;
               end
            end
            ST_COEF: begin
               coef_d_d = sext(eff_val_s);
               idx_d    = idx_inc_s;
               state_d  = ST_IDLE;
            end
            ST_FILL: begin
               idx_d = idx_inc_s;
               if (last_s) begin
                  state_d = eff_pend_e_s ? ST_EOS : ST_IDLE;
               end else begin
                  state_d = ST_FILL;
               end
            end
            ST_EOS: begin
               coef_e_d   = 1'b1;
               coef_idx_d = {IW{1'b0}};
               idx_d      = {IW{1'b0}};
               pend_e_d   = 1'b0;
               state_d    = ST_IDLE;
            end
            default: begin
               coef_v_d = 1'b0;
               state_d  = ST_IDLE;
            end
         endcase
      end else begin
         coef_v_d = coef_v_q;
      end
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_IDLE;
         idx_q      <= {IW{1'b0}};
         zcnt_q     <= 5'd0;
         val_q      <= {CW{1'b0}};
         zrl_q      <= 1'b0;
         pend_e_q   <= 1'b0;
         err_q      <= 1'b0;
         coef_v_q   <= 1'b0;
         coef_e_q   <= 1'b0;
         coef_d_q   <= 16'd0;
         coef_idx_q <= {IW{1'b0}};
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         zcnt_q     <= zcnt_d;
         val_q      <= val_d;
         zrl_q      <= zrl_d;
         pend_e_q   <= pend_e_d;
         err_q      <= err_d;
         coef_v_q   <= coef_v_d;
         coef_e_q   <= coef_e_d;
         coef_d_q   <= coef_d_d;
         coef_idx_q <= coef_idx_d;
      end
   end

   assign coef_v   = coef_v_q;
   assign coef_e   = coef_e_q;
   assign coef_d   = coef_d_q;
   assign coef_idx = coef_idx_q;
   assign err      = err_q;

endmodule

// File: tb/tb_dechuff_rle_expand.sv
// Directed bench for dechuff_rle_expand: a token-level model fills a scoreboard of
// expected beats, and a negedge monitor pops and compares every transferred beat.
module tb_dechuff_rle_expand;
   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] tok_d = 16'd0;
   logic        tok_e = 1'b0;
   logic        tok_v = 1'b0;
   logic        tok_b;
   logic [15:0] coef_d;
   logic [5:0]  coef_idx;
   logic        coef_e;
   logic        coef_v;
   logic        coef_b = 1'b0;
   logic        err;

   int          checks = 0;
   int          errors = 0;
   int          m_idx  = 0;
   logic        m_err  = 1'b0;
   logic [22:0] exp_q[$];
   logic [22:0] exp_beat;

   dechuff_rle_expand dut (
      .clock(clock), .reset(reset),
      .parsedToken_d(tok_d), .parsedToken_e(tok_e), .parsedToken_v(tok_v),
      .parsedToken_b(tok_b),
      .coef_d(coef_d), .coef_idx(coef_idx), .coef_e(coef_e), .coef_v(coef_v),
      .coef_b(coef_b), .err(err)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input bit e, input int idx, input logic [15:0] d);
      exp_q.push_back({e, 6'(idx), d});
   endtask

   // Token-level reference: appends the beats a token should produce.
   task automatic model_tok(input bit e, input logic [15:0] d);
      int run;
      logic [15:0] v;
      run = int'(d[15:12]);
      v   = {{4{d[11]}}, d[11:0]};
      if (e) begin
         if (m_idx != 0) for (int i = m_idx; i < 64; i++) push(1'b0, i, 16'd0);
         push(1'b1, 0, 16'd0);
         m_idx = 0;
      end else if (m_idx == 0) begin
         push(1'b0, 0, v);
         m_idx = 1;
      end else if (d == 16'h0000) begin
         for (int i = m_idx; i < 64; i++) push(1'b0, i, 16'd0);
         m_idx = 0;
      end else if (d == 16'hF000) begin
         if (m_idx + 16 > 64) m_err = 1'b1;
         for (int i = m_idx; i < m_idx + 16 && i < 64; i++) push(1'b0, i, 16'd0);
         m_idx = (m_idx + 16 >= 64) ? 0 : m_idx + 16;
      end else if (m_idx + run > 63) begin
         for (int i = m_idx; i < 64; i++) push(1'b0, i, 16'd0);
         m_err = 1'b1;
         m_idx = 0;
      end else begin
         for (int i = m_idx; i < m_idx + run; i++) push(1'b0, i, 16'd0);
         push(1'b0, m_idx + run, v);
         m_idx = (m_idx + run + 1) % 64;
      end
   endtask

   task automatic send(input bit e, input logic [15:0] d);
      model_tok(e, d);
      @(posedge clock); #1;
      tok_v = 1'b1;
      tok_d = d;
      tok_e = e;
      for (int n = 0; n < 200; n++) begin
         @(negedge clock);
         if (!tok_b) break;
      end
      chk("accept_ready", 32'(tok_b), 32'd0);
      @(posedge clock); #1;
      tok_v = 1'b0;
      tok_e = 1'b0;
      chk("first_beat_latency", 32'(coef_v), 32'd1);
   endtask

   task automatic drain(input string tag);
      for (int n = 0; n < 200 && exp_q.size() > 0; n++) @(negedge clock);
      @(negedge clock);
      chk({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
      chk({tag, "_err"}, 32'(err), 32'(m_err));
   endtask

   // Scoreboard monitor: every beat that transfers must match the next expected beat.
   always @(negedge clock) begin
      if (!reset && coef_v && !coef_b) begin
         chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            exp_beat = exp_q.pop_front();
            chk($sformatf("beat_idx%0d", exp_beat[21:16]),
                {9'd0, coef_e, coef_idx, coef_d}, {9'd0, exp_beat});
         end
      end
   end

   initial begin
      repeat (3) @(posedge clock);
      #1;
      chk("rst_coef_v", 32'(coef_v), 32'd0);
      chk("rst_coef_d", 32'(coef_d), 32'd0);
      chk("rst_coef_idx", 32'(coef_idx), 32'd0);
      chk("rst_coef_e", 32'(coef_e), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_tok_b", 32'(tok_b), 32'd0);
      reset = 1'b0;

      // DC, short run with negative value, EOB fill
      send(1'b0, 16'h0005);
      send(1'b0, 16'h2FFD);
      send(1'b0, 16'h0000);
      drain("basic");

      // three ZRLs and a run that lands exactly on index 63
      send(1'b0, 16'h0011);
      repeat (3) send(1'b0, 16'hF000);
      send(1'b0, 16'hE001);
      drain("exact63");
      send(1'b0, 16'h0007);
      chk("next_block_idx0", 32'(coef_idx), 32'd0);
      send(1'b0, 16'h0000);
      drain("exact63_close");

      // run overflowing the block from index 60
      send(1'b0, 16'h0002);
      repeat (3) send(1'b0, 16'hF000);
      send(1'b0, 16'hA004);
      send(1'b0, 16'hF007);
      drain("overflow");
      send(1'b0, 16'h0009);
      send(1'b0, 16'h0000);
      drain("after_overflow");

      // downstream stall in the middle of a zero run
      send(1'b0, 16'h0003);
      send(1'b0, 16'hF005);
      @(posedge clock); #1;
      coef_b = 1'b1;
      repeat (5) begin
         @(posedge clock); #1;
         chk("stall_v", 32'(coef_v), 32'd1);
         chk("stall_idx", 32'(coef_idx), 32'd2);
         chk("stall_d", 32'(coef_d), 32'd0);
         chk("stall_tok_b", 32'(tok_b), 32'd1);
      end
      coef_b = 1'b0;
      send(1'b0, 16'h0000);
      drain("stall");

      // end of stream mid-block and on a block boundary
      send(1'b0, 16'h0004);
      send(1'b0, 16'h8001);
      send(1'b1, 16'h1234);
      drain("eos_idx10");
      send(1'b1, 16'h0000);
      chk("eos_idx0_e", 32'(coef_e), 32'd1);
      chk("eos_idx0_idx", 32'(coef_idx), 32'd0);
      drain("eos_idx0");

      // reset during EOB fill at index 30
      send(1'b0, 16'h0006);
      send(1'b0, 16'hF000);
      send(1'b0, 16'hC002);
      send(1'b0, 16'h0000);
      chk("fill_start_idx", 32'(coef_idx), 32'd30);
      chk("err_before_reset", 32'(err), 32'd1);
      reset = 1'b1;
      @(posedge clock); #1;
      chk("midreset_coef_v", 32'(coef_v), 32'd0);
      chk("midreset_err", 32'(err), 32'd0);
      reset = 1'b0;
      exp_q.delete();
      m_idx = 0;
      m_err = 1'b0;
      send(1'b0, 16'h0003);
      chk("post_reset_idx", 32'(coef_idx), 32'd0);
      chk("post_reset_d", 32'(coef_d), 32'd3);
      send(1'b0, 16'h0000);
      drain("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
